// File: rtl/qed_dup_scheduler.sv
// -----------------------------------------------------------------------------
// qed_dup_scheduler
//
// Sits between the free formal instruction source and ridecore fetch and
// produces the QED instruction stream. In ORIG mode each valid original
// instruction goes to fetch and its duplicate is queued. In DUP mode the
// queued duplicates are issued in order. DONE tells the checker that every
// duplicate has been issued.
//
// The duplicate uses registers x16..x31. LW/SW duplicates address the upper
// half of dmem.
//
// Ports:
//   clk        clock
//   reset_x    asynchronous active-low reset
//   ena        fetch advancing; state and outputs update only when high
//   exec_dup   request switch to DUP mode (sampled when ena=1)
//   instr_in   original instruction (opcode 7'h7F = NOP)
//   instr_out  registered instruction to fetch
//   vld_out    registered instr_out valid
//   fifo_full  duplicate FIFO holds DEPTH entries
//   qed_ready  registered, sticky; all duplicates have been issued
//
// Optional feature (macro QED_DUP_STATS_EN):
//   orig_cnt / dup_cnt  saturating 16-bit counts of issued originals and
//   issued duplicates.
// -----------------------------------------------------------------------------
module qed_dup_scheduler #(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    parameter int MEM_BIT = 30
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        ena,
    input  logic        exec_dup,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic        vld_out,
    output logic        fifo_full,
    output logic        qed_ready
`ifdef QED_DUP_STATS_EN
    ,
    output logic [15:0] orig_cnt,
    output logic [15:0] dup_cnt
`endif
);

    localparam logic [31:0]    NOP_INSTR = 32'h0000_007F;
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef enum logic [1:0] {ST_ORIG, ST_DUP, ST_DONE} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      instr_out_q, instr_out_d;
    logic             vld_out_q, vld_out_d;
    logic             qed_ready_q, qed_ready_d;
    logic [31:0]      mem_q [DEPTH];

    logic [31:0]      dup_instr;
    logic             is_valid;
    logic             push;
    logic             pop;

    // Duplicate transform. Setting bit 4 of a register field maps x0..x15 onto
    // x16..x31. Any opcode outside R/I/LW/SW is treated as a NOP.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        dup_instr = instr_in;
        is_valid  = 1'b1;
        case (instr_in[6:0])
            OP_R: begin
                dup_instr[11] = 1'b1;   // rd
                dup_instr[19] = 1'b1;   // rs1
                dup_instr[24] = 1'b1;   // rs2
            end
            OP_I: begin
                dup_instr[11] = 1'b1;
                dup_instr[19] = 1'b1;
            end
            OP_LW: begin
                dup_instr[11]      = 1'b1;
                dup_instr[MEM_BIT] = 1'b1;
            end
            OP_SW: begin
                dup_instr[19]      = 1'b1; // base register only; rs2 keeps its data source
                dup_instr[MEM_BIT] = 1'b1;
            end
            default: is_valid = 1'b0;
        endcase
    end

    assign fifo_full = (count_q == FULL_CNT);
    assign push      = ena && (state_q == ST_ORIG) && is_valid && !fifo_full;
    assign pop       = ena && (state_q == ST_DUP) && (count_q != '0);

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) state_q <= ST_ORIG;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_ORIG: if (exec_dup) state_d = (count_q != '0 || push) ? ST_DUP : ST_DONE;
                ST_DUP:  if (count_q <= 1) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_ORIG;
            endcase
        end
    end

    // FSM: output and datapath next values
    always_comb begin
        instr_out_d = instr_out_q;
        vld_out_d   = vld_out_q;
        qed_ready_d = qed_ready_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (ena) begin
            instr_out_d = NOP_INSTR;
            vld_out_d   = 1'b0;
            if (push) begin
                instr_out_d = instr_in;
                vld_out_d   = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                count_d     = count_q + 1'b1;
            end else if (pop) begin
                instr_out_d = mem_q[rd_ptr_q];
                vld_out_d   = 1'b1;
                rd_ptr_d    = rd_ptr_q + 1'b1;
                count_d     = count_q - 1'b1;
            end
            if (state_q == ST_DONE) qed_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            instr_out_q <= NOP_INSTR;
            vld_out_q   <= 1'b0;
            qed_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            instr_out_q <= instr_out_d;
            vld_out_q   <= vld_out_d;
            qed_ready_q <= qed_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: storage is not reset; clearing count and pointers already discards it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dup_instr;
    end

    assign instr_out = instr_out_q;
    assign vld_out   = vld_out_q;
    assign qed_ready = qed_ready_q;

`ifdef QED_DUP_STATS_EN
    logic [15:0] orig_cnt_q, orig_cnt_d;
    logic [15:0] dup_cnt_q, dup_cnt_d;

    always_comb begin
        orig_cnt_d = orig_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        if (push && orig_cnt_q != 16'hFFFF) orig_cnt_d = orig_cnt_q + 16'd1;
        if (pop && dup_cnt_q != 16'hFFFF)   dup_cnt_d  = dup_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            orig_cnt_q <= '0;
            dup_cnt_q  <= '0;
        end else begin
            orig_cnt_q <= orig_cnt_d;
            dup_cnt_q  <= dup_cnt_d;
        end
    end

    assign orig_cnt = orig_cnt_q;
    assign dup_cnt  = dup_cnt_q;
`endif

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qed_dup_scheduler
//
// Self-checking bench for qed_dup_scheduler. A queue-based model of the
// scheduler predicts instr_out, vld_out, qed_ready, fifo_full and, when
// QED_DUP_STATS_EN is defined, the issue counters. The bench runs directed
// scenarios followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_qed_dup_scheduler;

    localparam logic [31:0] NOP = 32'h0000_007F;
    localparam int          CAP = 8;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        ena;
    logic        exec_dup;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic        vld_out;
    logic        fifo_full;
    logic        qed_ready;
`ifdef QED_DUP_STATS_EN
    logic [15:0] orig_cnt;
    logic [15:0] dup_cnt;
`endif

    int errors = 0;
    int checks = 0;

    qed_dup_scheduler dut (
        .clk       (clk),
        .reset_x   (reset_x),
        .ena       (ena),
        .exec_dup  (exec_dup),
        .instr_in  (instr_in),
        .instr_out (instr_out),
        .vld_out   (vld_out),
        .fifo_full (fifo_full),
        .qed_ready (qed_ready)
`ifdef QED_DUP_STATS_EN
        ,
        .orig_cnt  (orig_cnt),
        .dup_cnt   (dup_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] q[$];
    bit          m_dup_mode;
    bit          m_done;
    logic [31:0] exp_instr;
    logic        exp_vld;
    logic        exp_ready;
    int          m_orig;
    int          m_dupc;

    function automatic bit is_real(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23};
    endfunction

    // The duplicate is the original with fixed bits ORed in, chosen by opcode.
    function automatic logic [31:0] dup_of(input logic [31:0] i);
        case (i[6:0])
            7'h33:   return i | 32'h0108_0800;
            7'h13:   return i | 32'h0008_0800;
            7'h03:   return i | 32'h4000_0800;
            7'h23:   return i | 32'h4008_0000;
            default: return i;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_dup_mode = 0;
        m_done     = 0;
        exp_instr  = NOP;
        exp_vld    = 0;
        exp_ready  = 0;
        m_orig     = 0;
        m_dupc     = 0;
    endtask

    task automatic model_edge(input logic e, input logic x, input logic [31:0] i);
        if (!e) return;
        exp_instr = NOP;
        exp_vld   = 0;
        if (m_done) begin
            exp_ready = 1;
        end else if (m_dup_mode) begin
            exp_instr = q.pop_front();
            exp_vld   = 1;
            m_dupc    = (m_dupc < 16'hFFFF) ? m_dupc + 1 : m_dupc;
            if (q.size() == 0) m_done = 1;
        end else begin
            if (is_real(i) && q.size() < CAP) begin
                exp_instr = i;
                exp_vld   = 1;
                q.push_back(dup_of(i));
                m_orig = (m_orig < 16'hFFFF) ? m_orig + 1 : m_orig;
            end
            if (x) begin
                if (q.size() > 0) m_dup_mode = 1;
                else              m_done     = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/instr_out"}, instr_out, exp_instr);
        check({tag, "/vld_out"},   32'(vld_out),   32'(exp_vld));
        check({tag, "/qed_ready"}, 32'(qed_ready), 32'(exp_ready));
        check({tag, "/fifo_full"}, 32'(fifo_full), 32'(q.size() == CAP));
`ifdef QED_DUP_STATS_EN
        check({tag, "/orig_cnt"}, 32'(orig_cnt), 32'(m_orig));
        check({tag, "/dup_cnt"},  32'(dup_cnt),  32'(m_dupc));
`endif
    endtask

    // Drive inputs, take one clock edge, update the model, sample 1 ns later.
    task automatic step(input string tag, input logic e, input logic x, input logic [31:0] i);
        ena      = e;
        exec_dup = x;
        instr_in = i;
        @(posedge clk);
        model_edge(e, x, i);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic pulse_reset(input string tag);
        reset_x = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        reset_x = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4: op = 7'h7F;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    function automatic logic [31:0] rand_valid();
        logic [31:0] r;
        r = rand_instr();
        if (!is_real(r)) r[6:0] = 7'h13;
        return r;
    endfunction

    initial begin
        reset_x  = 1'b0;
        ena      = 1'b0;
        exec_dup = 1'b0;
        instr_in = NOP;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        reset_x = 1'b1;

        // 1: reset during traffic
        for (int k = 0; k < 5; k++) step("t1_traffic", 1'b1, 1'b0, rand_valid());
        pulse_reset("t1_reset");
        check("t1_instr_nop", instr_out, NOP);
        check("t1_full_low", 32'(fifo_full), 32'd0);

        // 2: ADD original, then its duplicate, then qed_ready
        step("t2_add", 1'b1, 1'b0, 32'h003100B3);
        check("t2_orig", instr_out, 32'h003100B3);
        step("t2_exec", 1'b1, 1'b1, NOP);
        step("t2_dup", 1'b1, 1'b0, NOP);
        check("t2_dup_val", instr_out, 32'h013908B3);
        step("t2_done", 1'b1, 1'b0, NOP);
        check("t2_ready", 32'(qed_ready), 32'd1);
        pulse_reset("t2_reset");

        // 3: LW with exec_dup on the same edge
        step("t3_lw", 1'b1, 1'b1, 32'h00802283);
        check("t3_orig", instr_out, 32'h00802283);
        step("t3_dup", 1'b1, 1'b0, NOP);
        check("t3_dup_val", instr_out, 32'h40802A83);
        step("t3_done", 1'b1, 1'b0, NOP);
        pulse_reset("t3_reset");

        // 4: overflow, 9th original dropped, then 8 duplicates in order
        for (int k = 0; k < 9; k++) begin
            step("t4_fill", 1'b1, 1'b0, rand_valid());
            if (k == 7) check("t4_full", 32'(fifo_full), 32'd1);
        end
        check("t4_drop_vld", 32'(vld_out), 32'd0);
        step("t4_exec", 1'b1, 1'b1, NOP);
        for (int k = 0; k < 8; k++) step("t4_pop", 1'b1, 1'b0, rand_instr());
        step("t4_done", 1'b1, 1'b0, NOP);
        check("t4_ready", 32'(qed_ready), 32'd1);
`ifdef QED_DUP_STATS_EN
        check("t4_orig_cnt", 32'(orig_cnt), 32'd8);
        check("t4_dup_cnt", 32'(dup_cnt), 32'd8);
`endif
        pulse_reset("t4_reset");

        // 5: ena low for 3 cycles in the middle of DUP
        for (int k = 0; k < 5; k++) step("t5_fill", 1'b1, 1'b0, rand_valid());
        step("t5_exec", 1'b1, 1'b1, NOP);
        step("t5_pop", 1'b1, 1'b0, NOP);
        step("t5_pop", 1'b1, 1'b0, NOP);
        for (int k = 0; k < 3; k++) begin
            step("t5_hold", 1'b0, 1'b1, rand_instr());
            check("t5_hold_vld", 32'(vld_out), 32'd1);
        end
        for (int k = 0; k < 4; k++) step("t5_resume", 1'b1, 1'b0, rand_instr());
        pulse_reset("t5_reset");

        // 6: reset mid-DUP with 4 entries queued
        for (int k = 0; k < 4; k++) step("t6_fill", 1'b1, 1'b0, rand_valid());
        step("t6_exec", 1'b1, 1'b1, NOP);
        pulse_reset("t6_reset");
        step("t6_exec_nop", 1'b1, 1'b1, NOP);
        check("t6_no_vld", 32'(vld_out), 32'd0);
        step("t6_done", 1'b1, 1'b0, NOP);
        check("t6_ready", 32'(qed_ready), 32'd1);
        pulse_reset("t6_reset2");

        // randomized traffic
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 199) == 0) pulse_reset("rnd_reset");
                else step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), rand_instr());
            end
            pulse_reset("rnd_round");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
